out_port_alloc: RTL and testbench
=================================

Name: out_port_alloc

Overview:
- Per-output-port allocator for the RN router.
- Sits downstream of the per-input request logic and upstream of the crossbar.
- Each cycle it picks one input among those requesting this output. It rotates priority by a round-robin pointer, holds the grant for a whole wormhole packet (head to tail), and gates every grant on downstream buffer credits.
- It drives one-hot grants back to the inputs and a registered select to the crossbar.

Parameters:
- NUM_IN, 4, number of input ports competing for this output (>=2).
- CREDIT_DEPTH, 4, downstream buffer depth in flits; credit counter reset value.
- LOG2_NUM_IN, $clog2(NUM_IN), derived localparam; width of index fields.
- CNT_W, $clog2(CREDIT_DEPTH+1), derived localparam; credit counter width.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_IN  per-input request: a flit destined for this output is at that input's head.
- req_tail  input  NUM_IN  per-input flag: the presented flit is a tail (a single-flit packet sets head and tail together).
- credit_ret  input  1  one credit returned by downstream this cycle.
- gnt  output  NUM_IN  one-hot grant, combinational, same cycle as req; the flit transfers when gnt[i]=1.
- gnt_idx  output  LOG2_NUM_IN  binary index of gnt; 0 when no grant.
- gnt_valid  output  1  OR of gnt.
- xbar_sel  output  LOG2_NUM_IN  registered gnt_idx, aligned with the crossbar's registered stage.
- xbar_valid  output  1  registered gnt_valid.
- locked  output  1  packet in flight; grant is held to lock_idx.
- credit_cnt  output  CNT_W  current downstream credits.
- err_credit  output  1  sticky: credit returned while the counter was already at CREDIT_DEPTH.

Behaviour:
- Reset (async assert, sync-style deassert handled upstream) sets the following; gnt, gnt_idx and gnt_valid are 0 whenever req=0.
  - rr_ptr=0, locked=0, lock_idx=0
  - credit_cnt=CREDIT_DEPTH
  - xbar_sel=0, xbar_valid=0, err_credit=0
- Credit gate: has_credit = (credit_cnt != 0). No grant is issued when has_credit=0, regardless of state.
- State machine with two states, IDLE (locked=0) and LOCKED (locked=1).
- IDLE:
  - masked = req & (all-ones << rr_ptr).
  - Pick the lowest set bit of masked if masked is nonzero; otherwise the lowest set bit of req.
  - Grant the pick if has_credit.
  - If the granted flit is not a tail: go to LOCKED and set lock_idx = the pick.
  - If it is a tail (single-flit packet): stay IDLE and set rr_ptr = (pick+1) mod NUM_IN.
- LOCKED:
  - gnt[lock_idx] = req[lock_idx] & has_credit; all other inputs are ignored.
  - When a granted flit has req_tail[lock_idx]=1: go to IDLE and set rr_ptr = (lock_idx+1) mod NUM_IN.
  - A bubble (req[lock_idx]=0) keeps the lock; no grant is issued.
- rr_ptr changes only on tail transfer.
- Pointer wrap: when the pick is NUM_IN-1, rr_ptr becomes 0.
- Credits:
  - next = cnt - gnt_valid + credit_ret; grant and return in the same cycle is net zero.
  - Return while cnt == CREDIT_DEPTH with no grant: cnt saturates at CREDIT_DEPTH and err_credit sets. err_credit clears only on reset.
  - A counter underflow is impossible by construction (grant is gated).
- Latency:
  - gnt is issued in cycle 0, combinationally.
  - xbar_sel and xbar_valid are valid in cycle 1.
  - credit_cnt reflects the grant in cycle 1.
- Reset mid-packet drops the lock immediately and restores full credits. Upstream is responsible for flushing the partial packet.
- Invariants for verification:
  - gnt is one-hot or zero.
  - gnt is never nonzero while credit_cnt==0.
  - In LOCKED, gnt is never set to an input other than lock_idx.

Decomposition:
- Shared package rn_pkg holds:
  - the NUM_IN and CREDIT_DEPTH defaults
  - the alloc_state_e enum {IDLE, LOCKED}
  - an index type sized by LOG2_NUM_IN
- Sub-module lsb_pick (combinational: vector -> one-hot lowest set bit, binary index, found flag), instantiated twice (masked path and raw path).
- All sequential logic stays in out_port_alloc.

Test Plan:
- Single-flit round robin: req=4'b1111, req_tail=4'b1111, credits=4, credit_ret=1 every cycle -> gnt goes 0001, 0010, 0100, 1000, 0001; rr_ptr goes 1, 2, 3, 0, 1; credit_cnt stays 4.
- Wormhole lock: input 2 sends a 3-flit packet (tail on the 3rd) while req=4'b0111 throughout, no credit_ret.
  - gnt=0100 for 3 cycles with locked=1 during flits 1-2.
  - Then IDLE, rr_ptr=3, next gnt=0001.
  - credit_cnt = 1 after 3 flits.
- Credit exhaustion: CREDIT_DEPTH=4, req=4'b0001 non-tail, no returns.
  - 4 grants, credit_cnt=0, gnt=0 on the 5th cycle.
  - Pulse credit_ret -> one grant the next cycle; credit_cnt goes 1 then 0.
- Simultaneous grant and return at credit_cnt=2 -> stays 2. Return at credit_cnt=4 with no grant -> stays 4 and err_credit=1, sticky.
- Bubble in lock: locked on input 1, req[1] drops for 2 cycles while req[0]=1 -> gnt=0 for both cycles; lock_idx=1 held; resume grants input 1.
- Async reset mid-packet: assert rst_n=0 between clock edges while locked with credit_cnt=1 -> immediately locked=0, credit_cnt=4, xbar_valid=0, rr_ptr=0.

Source files
------------

// File: rtl/rn_pkg.sv
// Shared definitions for the RN router output-port allocator:
// default sizes, the allocator state encoding and the input index type.
package rn_pkg;

   localparam int NUM_IN_DEF       = 4;
   localparam int CREDIT_DEPTH_DEF = 4;
   localparam int LOG2_NUM_IN_DEF  = $clog2(NUM_IN_DEF);

   typedef logic [LOG2_NUM_IN_DEF-1:0] idx_t;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } alloc_state_e;

endpackage

// File: rtl/out_port_alloc_if.sv
// Request/grant bundle between the per-input request logic and one output allocator.
// A flit at input i transfers in the cycle req[i]=1 and gnt[i]=1; gnt is a same-cycle
// combinational answer to req, and req_tail qualifies the flit presented alongside req.
interface out_port_alloc_if #(
   parameter int NUM_IN      = 4,
   parameter int LOG2_NUM_IN = $clog2(NUM_IN)
);

   logic [NUM_IN-1:0]      req;
   logic [NUM_IN-1:0]      req_tail;
   logic [NUM_IN-1:0]      gnt;
   logic [LOG2_NUM_IN-1:0] gnt_idx;
   logic                   gnt_valid;

   modport master (
      output req, req_tail,
      input  gnt, gnt_idx, gnt_valid
   );

   modport slave (
      input  req, req_tail,
      output gnt, gnt_idx, gnt_valid
   );

endinterface

// File: rtl/lsb_pick.sv
// Lowest-set-bit finder: one-hot of the lowest set bit, its binary index, and a found flag.
module lsb_pick #(
   parameter int W  = 4,
   parameter int IW = $clog2(W)
) (
   input  logic [W-1:0]  vec,
   output logic [W-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          found
);

   assign onehot = vec & (~vec + W'(1));
   assign found  = |vec;

   // Scanning downward lets the lowest set bit win the last assignment.
   always_comb begin
      idx = '0;
      for (int i = W - 1; i >= 0; i--) begin
         if (vec[i]) idx = IW'(i);
      end
   end

endmodule

// File: rtl/out_port_alloc.sv
// Per-output-port allocator: round-robin pick among requesting inputs, wormhole lock
// from head to tail, and grants gated by downstream buffer credits.
module out_port_alloc
   import rn_pkg::*;
#(
   parameter int NUM_IN       = NUM_IN_DEF,
   parameter int CREDIT_DEPTH = CREDIT_DEPTH_DEF,
   localparam int LOG2_NUM_IN = $clog2(NUM_IN),
   localparam int CNT_W       = $clog2(CREDIT_DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   out_port_alloc_if.slave        bus,
   input  logic                   credit_ret,
   output logic [LOG2_NUM_IN-1:0] xbar_sel,
   output logic                   xbar_valid,
   output logic                   locked,
   output logic [CNT_W-1:0]       credit_cnt,
   output logic                   err_credit,
   output alloc_state_e           state,
   output logic [LOG2_NUM_IN-1:0] rr_ptr,
   output logic [LOG2_NUM_IN-1:0] lock_idx
);

   localparam logic [LOG2_NUM_IN-1:0] LAST_IDX = LOG2_NUM_IN'(NUM_IN - 1);
   localparam logic [CNT_W-1:0]       FULL_CNT = CNT_W'(CREDIT_DEPTH);

   logic [NUM_IN-1:0]      masked;
   logic [NUM_IN-1:0]      m_oh, r_oh;
   logic [LOG2_NUM_IN-1:0] m_idx, r_idx;
   logic                   m_found, r_found;
   logic [NUM_IN-1:0]      gnt_w;
   logic [LOG2_NUM_IN-1:0] gnt_idx_w;
   logic                   gnt_valid_w;
   logic                   has_credit;
   logic                   tail_xfer;
   logic [LOG2_NUM_IN-1:0] rr_next;

   assign has_credit = (credit_cnt != '0);
   assign masked     = bus.req & ({NUM_IN{1'b1}} << rr_ptr);

   lsb_pick #(.W(NUM_IN), .IW(LOG2_NUM_IN)) u_pick_masked (
      .vec    (masked),
      .onehot (m_oh),
      .idx    (m_idx),
      .found  (m_found)
   );

   lsb_pick #(.W(NUM_IN), .IW(LOG2_NUM_IN)) u_pick_raw (
      .vec    (bus.req),
      .onehot (r_oh),
      .idx    (r_idx),
      .found  (r_found)
   );

   // While locked only the owning input is considered; a bubble yields no grant.
   always_comb begin
      gnt_w     = '0;
      gnt_idx_w = '0;
      if (has_credit) begin
         if (state == IDLE) begin
            if (r_found) begin
               gnt_w     = m_found ? m_oh  : r_oh;
               gnt_idx_w = m_found ? m_idx : r_idx;
            end
         end else if (bus.req[lock_idx]) begin
            gnt_w[lock_idx] = 1'b1;
            gnt_idx_w       = lock_idx;
         end
      end
   end

   assign gnt_valid_w   = |gnt_w;
   assign tail_xfer     = gnt_valid_w & bus.req_tail[gnt_idx_w];
   assign rr_next       = (gnt_idx_w == LAST_IDX) ? '0 : gnt_idx_w + LOG2_NUM_IN'(1);
   assign bus.gnt       = gnt_w;
   assign bus.gnt_idx   = gnt_idx_w;
   assign bus.gnt_valid = gnt_valid_w;
   assign locked        = (state == LOCKED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         lock_idx   <= '0;
         credit_cnt <= FULL_CNT;
         err_credit <= 1'b0;
         xbar_sel   <= '0;
         xbar_valid <= 1'b0;
      end else begin
         xbar_sel   <= gnt_idx_w;
         xbar_valid <= gnt_valid_w;

         case (state)
            IDLE: begin
               if (gnt_valid_w) begin
                  if (tail_xfer) begin
                     rr_ptr <= rr_next;
                  end else begin
                     state    <= LOCKED;
                     lock_idx <= gnt_idx_w;
                  end
               end
            end
            LOCKED: begin
               if (tail_xfer) begin
                  state  <= IDLE;
                  rr_ptr <= rr_next;
               end
            end
            default: state <= IDLE;
         endcase

         // Grant and return in the same cycle cancel; a return at full credit saturates.
         case ({gnt_valid_w, credit_ret})
            2'b10: credit_cnt <= credit_cnt - CNT_W'(1);
            2'b01: begin
               if (credit_cnt == FULL_CNT) err_credit <= 1'b1;
               else                        credit_cnt <= credit_cnt + CNT_W'(1);
            end
            default: credit_cnt <= credit_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_out_port_alloc.sv
// Directed bench for out_port_alloc: expected grants are queued by the driver and
// checked by a negedge monitor; registered state is checked directly between cycles.
module tb_out_port_alloc;
   import rn_pkg::*;

   localparam int W = 10; // {gnt[3:0], gnt_idx[1:0], credit_cnt[2:0], locked}

   logic       clk;
   logic       rst_n;
   logic       credit_ret;
   logic [1:0] xbar_sel;
   logic       xbar_valid;
   logic       locked;
   logic [2:0] credit_cnt;
   logic       err_credit;
   alloc_state_e state;
   idx_t       rr_ptr;
   idx_t       lock_idx;

   logic [W-1:0] exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;

   out_port_alloc_if #(.NUM_IN(4)) bus ();

   out_port_alloc #(.NUM_IN(4), .CREDIT_DEPTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .credit_ret (credit_ret),
      .xbar_sel   (xbar_sel),
      .xbar_valid (xbar_valid),
      .locked     (locked),
      .credit_cnt (credit_cnt),
      .err_credit (err_credit),
      .state      (state),
      .rr_ptr     (rr_ptr),
      .lock_idx   (lock_idx)
   );

   // clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] r, input logic [3:0] t, input logic c);
      bus.req    = r;
      bus.req_tail = t;
      credit_ret = c;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic [3:0] r, input logic [3:0] t, input logic c);
      drive(r, t, c);
      tick();
   endtask

   task automatic exp_gnt(input logic [3:0] g, input logic [1:0] idx,
                          input logic [2:0] cnt, input logic lk);
      exp_q.push_back({g, idx, cnt, lk});
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst_n) begin
         check("gnt_onehot", 32'((bus.gnt & (bus.gnt - 4'd1)) == 4'd0), 32'd1);
         if (credit_cnt == 3'd0) check("gnt_no_credit", 32'(bus.gnt), 32'd0);
         if (bus.gnt_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_gnt", 32'(bus.gnt), 32'd0);
            end else begin
               check("gnt_pkt", 32'({bus.gnt, bus.gnt_idx, credit_cnt, locked}),
                     32'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      drive(4'b0000, 4'b0000, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_credit", 32'(credit_cnt), 32'd4);
      check("rst_xbar_valid", 32'(xbar_valid), 32'd0);
      check("rst_xbar_sel", 32'(xbar_sel), 32'd0);
      check("rst_err", 32'(err_credit), 32'd0);
      check("rst_rr", 32'(rr_ptr), 32'd0);
      check("rst_gnt", 32'(bus.gnt), 32'd0);
      check("rst_gnt_valid", 32'(bus.gnt_valid), 32'd0);
      tick();

      // single-flit round robin with credit returned every cycle
      exp_gnt(4'b0001, 2'd0, 3'd4, 1'b0); cyc(4'b1111, 4'b1111, 1'b1);
      check("rr_ptr_a", 32'(rr_ptr), 32'd1);
      exp_gnt(4'b0010, 2'd1, 3'd4, 1'b0); cyc(4'b1111, 4'b1111, 1'b1);
      check("rr_ptr_b", 32'(rr_ptr), 32'd2);
      exp_gnt(4'b0100, 2'd2, 3'd4, 1'b0); cyc(4'b1111, 4'b1111, 1'b1);
      check("rr_ptr_c", 32'(rr_ptr), 32'd3);
      exp_gnt(4'b1000, 2'd3, 3'd4, 1'b0); cyc(4'b1111, 4'b1111, 1'b1);
      check("rr_wrap", 32'(rr_ptr), 32'd0);
      check("xbar_sel_3", 32'(xbar_sel), 32'd3);
      exp_gnt(4'b0001, 2'd0, 3'd4, 1'b0); cyc(4'b1111, 4'b1111, 1'b1);
      check("rr_ptr_e", 32'(rr_ptr), 32'd1);
      check("rr_credit", 32'(credit_cnt), 32'd4);
      check("xbar_valid_1", 32'(xbar_valid), 32'd1);
      check("xbar_sel_0", 32'(xbar_sel), 32'd0);
      cyc(4'b0000, 4'b0000, 1'b0);
      check("xbar_valid_0", 32'(xbar_valid), 32'd0);

      // move pointer to 2, then 3-flit wormhole from input 2
      exp_gnt(4'b0010, 2'd1, 3'd4, 1'b0); cyc(4'b0010, 4'b0010, 1'b1);
      check("wh_rr_pre", 32'(rr_ptr), 32'd2);
      exp_gnt(4'b0100, 2'd2, 3'd4, 1'b0); cyc(4'b0111, 4'b0000, 1'b0);
      check("wh_locked", 32'(locked), 32'd1);
      check("wh_lock_idx", 32'(lock_idx), 32'd2);
      check("wh_cnt1", 32'(credit_cnt), 32'd3);
      exp_gnt(4'b0100, 2'd2, 3'd3, 1'b1); cyc(4'b0111, 4'b0000, 1'b0);
      exp_gnt(4'b0100, 2'd2, 3'd2, 1'b1); cyc(4'b0111, 4'b0100, 1'b0);
      check("wh_unlocked", 32'(locked), 32'd0);
      check("wh_rr", 32'(rr_ptr), 32'd3);
      check("wh_cnt3", 32'(credit_cnt), 32'd1);
      exp_gnt(4'b0001, 2'd0, 3'd1, 1'b0); cyc(4'b0111, 4'b0001, 1'b1);
      check("wh_next_rr", 32'(rr_ptr), 32'd1);
      check("wh_next_cnt", 32'(credit_cnt), 32'd1);
      repeat (3) cyc(4'b0000, 4'b0000, 1'b1);
      check("refill_a", 32'(credit_cnt), 32'd4);

      // credit exhaustion on a long packet from input 0
      exp_gnt(4'b0001, 2'd0, 3'd4, 1'b0); cyc(4'b0001, 4'b0000, 1'b0);
      exp_gnt(4'b0001, 2'd0, 3'd3, 1'b1); cyc(4'b0001, 4'b0000, 1'b0);
      exp_gnt(4'b0001, 2'd0, 3'd2, 1'b1); cyc(4'b0001, 4'b0000, 1'b0);
      exp_gnt(4'b0001, 2'd0, 3'd1, 1'b1); cyc(4'b0001, 4'b0000, 1'b0);
      check("ex_cnt0", 32'(credit_cnt), 32'd0);
      check("ex_locked", 32'(locked), 32'd1);
      drive(4'b0001, 4'b0000, 1'b0); #2;
      check("ex_gnt_blocked", 32'(bus.gnt), 32'd0);
      tick();
      drive(4'b0001, 4'b0000, 1'b1); #2;
      check("ex_gnt_blocked_ret", 32'(bus.gnt), 32'd0);
      tick();
      check("ex_cnt_ret", 32'(credit_cnt), 32'd1);
      exp_gnt(4'b0001, 2'd0, 3'd1, 1'b1); cyc(4'b0001, 4'b0000, 1'b0);
      check("ex_cnt_again0", 32'(credit_cnt), 32'd0);
      cyc(4'b0000, 4'b0000, 1'b1);
      exp_gnt(4'b0001, 2'd0, 3'd1, 1'b1); cyc(4'b0001, 4'b0001, 1'b1);
      check("ex_tail_unlock", 32'(locked), 32'd0);
      check("ex_tail_rr", 32'(rr_ptr), 32'd1);
      check("ex_tail_cnt", 32'(credit_cnt), 32'd1);

      // simultaneous grant and return, then overflow return
      cyc(4'b0000, 4'b0000, 1'b1);
      check("sim_pre", 32'(credit_cnt), 32'd2);
      exp_gnt(4'b0010, 2'd1, 3'd2, 1'b0); cyc(4'b0010, 4'b0010, 1'b1);
      check("sim_net_zero", 32'(credit_cnt), 32'd2);
      check("sim_rr", 32'(rr_ptr), 32'd2);
      repeat (2) cyc(4'b0000, 4'b0000, 1'b1);
      check("full_cnt", 32'(credit_cnt), 32'd4);
      check("err_clear", 32'(err_credit), 32'd0);
      cyc(4'b0000, 4'b0000, 1'b1);
      check("ovf_cnt", 32'(credit_cnt), 32'd4);
      check("ovf_err", 32'(err_credit), 32'd1);
      cyc(4'b0000, 4'b0000, 1'b0);
      check("err_sticky", 32'(err_credit), 32'd1);

      // bubble while locked on input 1
      exp_gnt(4'b0010, 2'd1, 3'd4, 1'b0); cyc(4'b0010, 4'b0000, 1'b0);
      check("bub_locked", 32'(locked), 32'd1);
      check("bub_lock_idx", 32'(lock_idx), 32'd1);
      for (int i = 0; i < 2; i++) begin
         drive(4'b0001, 4'b0000, 1'b0); #2;
         check("bub_gnt", 32'(bus.gnt), 32'd0);
         tick();
      end
      check("bub_hold_idx", 32'(lock_idx), 32'd1);
      check("bub_hold_lock", 32'(locked), 32'd1);
      exp_gnt(4'b0010, 2'd1, 3'd3, 1'b1); cyc(4'b0011, 4'b0010, 1'b0);
      check("bub_unlock", 32'(locked), 32'd0);
      check("bub_rr", 32'(rr_ptr), 32'd2);
      check("bub_cnt", 32'(credit_cnt), 32'd2);
      repeat (2) cyc(4'b0000, 4'b0000, 1'b1);

      // asynchronous reset in the middle of a packet
      exp_gnt(4'b0100, 2'd2, 3'd4, 1'b0); cyc(4'b0100, 4'b0000, 1'b0);
      exp_gnt(4'b0100, 2'd2, 3'd3, 1'b1); cyc(4'b0100, 4'b0000, 1'b0);
      exp_gnt(4'b0100, 2'd2, 3'd2, 1'b1); cyc(4'b0100, 4'b0000, 1'b0);
      check("pre_rst_cnt", 32'(credit_cnt), 32'd1);
      check("pre_rst_locked", 32'(locked), 32'd1);
      check("pre_rst_xv", 32'(xbar_valid), 32'd1);
      check("pre_rst_xs", 32'(xbar_sel), 32'd2);
      drive(4'b0000, 4'b0000, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_locked", 32'(locked), 32'd0);
      check("arst_cnt", 32'(credit_cnt), 32'd4);
      check("arst_xv", 32'(xbar_valid), 32'd0);
      check("arst_rr", 32'(rr_ptr), 32'd0);
      check("arst_err", 32'(err_credit), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
